// File: rtl/muldiv_ctrl.sv
// ============================================================================
//  Module      : muldiv_ctrl
//  Description : Sequencer between the EX stage and the shared div_mlt unit.
//                It issues MULT/MULTU/DIV/DIVU, counts the unit latency and
//                commits HI/LO. It also services MTHI/MTLO.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_ctrl #(
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 33,
    parameter int CNT_W   = 6
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [1:0]  i_op,
    input  logic [31:0] i_rs,
    input  logic [31:0] i_rt,
    input  logic        i_mthi,
    input  logic        i_mtlo,
    input  logic [31:0] i_wdata,
    input  logic        i_flush,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_dz,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        o_dm_en,
    output logic        o_dm_mul,
    output logic        o_dm_sign,
    output logic [31:0] o_dm_A,
    output logic [31:0] o_dm_B,
    input  logic [31:0] i_dm_hi,
    input  logic [31:0] i_dm_lo,
    input  logic        i_dm_zero
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_mul_cnt = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] c_div_cnt = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        hi_q;
    logic [31:0]        lo_q;
    logic [31:0]        a_q;
    logic [31:0]        b_q;
    logic               mul_q;
    logic               sign_q;
    logic               en_q;
    logic               done_q;
    logic               dz_q;

    logic               w_accept_st;
    logic               w_accept;
    logic               w_mt_ok;

    // Requests and MTHI/MTLO are only honoured between operations.
    assign w_accept_st = (state_q == S_IDLE) || (state_q == S_DONE);
    assign w_accept    = w_accept_st && i_start && !i_flush;
    assign w_mt_ok     = w_accept_st && !i_start;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            mul_q   <= 1'b0;
            sign_q  <= 1'b0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            en_q   <= 1'b0;
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        a_q     <= i_rs;
                        b_q     <= i_rt;
                        mul_q   <= ~i_op[1];
                        sign_q  <= ~i_op[0];
                        en_q    <= 1'b1;
                        state_q <= S_ISSUE;
                    end else begin
                        state_q <= S_IDLE;
                    end
                    // An MTHI/MTLO in DONE overrides the just-committed result.
                    if (w_mt_ok && i_mthi) begin
                        hi_q <= i_wdata;
                    end
                    if (w_mt_ok && i_mtlo) begin
                        lo_q <= i_wdata;
                    end
                end
                S_ISSUE: begin
                    if (i_flush) begin
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q   <= mul_q ? c_mul_cnt : c_div_cnt;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_flush) begin
                        state_q <= S_IDLE;
                    end else if (cnt_q == '0) begin
                        if (mul_q || !i_dm_zero) begin
                            hi_q <= i_dm_hi;
                            lo_q <= i_dm_lo;
                        end
                        dz_q    <= !mul_q && i_dm_zero;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q - c_cnt_one;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy    = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign o_done    = done_q;
    assign o_dz      = dz_q;
    assign o_hi      = hi_q;
    assign o_lo      = lo_q;
    assign o_dm_en   = en_q;
    assign o_dm_mul  = mul_q;
    assign o_dm_sign = sign_q;
    assign o_dm_A    = a_q;
    assign o_dm_B    = b_q;

endmodule

`default_nettype wire
